// File: rtl/ram_bus_master_if.sv
// ram_bus_master_if: command, write-data and read-data channels of ram_bus_master
interface ram_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       wd_valid;
  logic       wd_ready;
  logic [7:0] wd_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       done;
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, wd_valid, wd_data,
    input  cmd_ready, wd_ready, rd_valid, rd_data, done
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, wd_valid, wd_data,
    output cmd_ready, wd_ready, rd_valid, rd_data, done
  );
endinterface

// File: rtl/ram_bus_master.sv
// ram_bus_master: burst read/write master for a simple RAM bus; MEM_PRESET_EN enables the preset command
module ram_bus_master #(
  parameter int TURN_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  ram_bus_master_if.slave bus,
  inout  wire  [7:0]      data,
  output logic [3:0]      address,
  output logic            read,
  output logic            write,
  output logic            preset
);
  typedef enum logic [2:0] {IDLE, RD, WR, PRE, TURN} state_t;
  state_t     state, state_n;
  logic [3:0] beat_addr, beat_cnt;
  logic [1:0] turn_cnt;
  logic       drive, advance, accept;
`ifdef MEM_PRESET_EN
  localparam state_t PRE_NEXT = PRE;
  assign preset = state == PRE;
`else
  localparam state_t PRE_NEXT = TURN;
  assign preset = 1'b0;
`endif
  assign data = drive ? bus.wd_data : 'z;
  // next state and bus outputs; a write beat only advances when write data is offered
  always_comb begin
    state_n       = state;
    read          = 1'b0;
    write         = 1'b0;
    address       = 4'd0;
    drive         = 1'b0;
    advance       = 1'b0;
    accept        = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.wd_ready  = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        accept        = bus.cmd_valid;
        if (bus.cmd_valid)
          state_n = bus.cmd_op == 2'b00 ? RD : bus.cmd_op == 2'b01 ? WR : bus.cmd_op == 2'b10 ? PRE_NEXT : TURN;
      end
      RD: begin
        read    = 1'b1;
        address = beat_addr;
        advance = 1'b1;
        if (beat_cnt == 4'd0) state_n = TURN;
      end
      WR: begin
        bus.wd_ready = 1'b1;
        write        = bus.wd_valid;
        drive        = bus.wd_valid;
        address      = beat_addr;
        advance      = bus.wd_valid;
        if (bus.wd_valid && beat_cnt == 4'd0) state_n = TURN;
      end
      PRE:  state_n = TURN;
      TURN: if (turn_cnt == 2'(TURN_CYCLES - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // beat address/count, turnaround timer, read capture and completion pulse
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      beat_addr    <= 4'd0;
      beat_cnt     <= 4'd0;
      turn_cnt     <= 2'd0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= 8'd0;
      bus.done     <= 1'b0;
    end else begin
      if (accept) begin
        beat_addr <= bus.cmd_addr;
        beat_cnt  <= bus.cmd_len;
      end else if (advance) begin
        beat_addr <= beat_addr + 4'd1;
        beat_cnt  <= beat_cnt - 4'd1;
      end
      turn_cnt     <= state == TURN ? turn_cnt + 2'd1 : 2'd0;
      bus.rd_valid <= state == RD;
      if (state == RD) bus.rd_data <= data;
      bus.done     <= state == TURN && state_n == IDLE;
    end
endmodule
